mac_acc_unit: RTL and testbench

//  Channel-reduction accumulator directly downstream of the INT8 MAC cell.
//  - Sums cfg_acc_len+1 consecutive valid 19-bit MAC partial sums into one signed ACC_W result.
//  - Queues results in a small FIFO and presents them on a valid/ready port.
//  - Upstream has no backpressure; if a result meets a full FIFO, the result is dropped and flagged.

---
 rtl/mac_acc_pkg.sv | 38 +++
 rtl/mac_acc_fifo.sv | 66 ++++++
 rtl/mac_acc_unit.sv | 155 +++++++++++++++
 tb/tb_mac_acc_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg: shared widths, FSM state type and the saturating adder
// used by the channel-reduction accumulator.
package mac_acc_pkg;

    localparam int IN_W_DEF       = 19;
    localparam int ACC_W_DEF      = 32;
    localparam int LEN_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    // Adds two w-bit signed values (sign-extended to 64 bits) and clamps
    // the sum into the signed w-bit range. Returns {clamped, sum}.
    function automatic logic [64:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic [64:0]        r;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        r  = {1'b0, s};
        if (s > hi) begin
            r = {1'b1, hi};
        end else if (s < lo) begin
            r = {1'b1, lo};
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_acc_fifo.sv
// mac_acc_fifo: small synchronous result FIFO. No fall-through; a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module mac_acc_fifo
    import mac_acc_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_acc_unit.sv
// mac_acc_unit: sums cfg_acc_len+1 valid MAC partial sums into one signed
// result, queues results and presents them on a valid/ready port.
module mac_acc_unit
    import mac_acc_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             cfg_reg_en,
    input  logic [LEN_W-1:0] cfg_acc_len,
    input  logic             cfg_sat_en,
    input  logic [IN_W-1:0]  mac_out_data,
    input  logic             mac_out_pvld,
    output logic [ACC_W-1:0] acc_out_data,
    output logic             acc_out_sat,
    output logic             acc_out_pvld,
    input  logic             acc_out_prdy,
    output logic             acc_busy,
    output logic             acc_ovf_err
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
    logic             cfg_sat_q, cfg_sat_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] data_ext;
    logic [64:0]      sa;
    logic             sa_clip;
    logic [63-ACC_W:0] sa_hi_unused;
    logic [ACC_W-1:0] sa_sum;
    logic [ACC_W-1:0] wrap_sum;
    logic [ACC_W-1:0] beat_sum;
    logic             beat_clip;

    logic             push;
    logic [ACC_W:0]   push_data;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ACC_W:0]   fifo_head;

    assign data_ext = {{(ACC_W - IN_W){mac_out_data[IN_W-1]}}, mac_out_data};

    assign sa = sat_add({{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q},
                        {{(64 - ACC_W){data_ext[ACC_W-1]}}, data_ext},
                        ACC_W);
    assign {sa_clip, sa_hi_unused, sa_sum} = sa;

    assign wrap_sum  = acc_q + data_ext;
    assign beat_sum  = cfg_sat_q ? sa_sum : wrap_sum;
    assign beat_clip = cfg_sat_q & sa_clip;

    assign pop = acc_out_pvld & acc_out_prdy;

    // FSM, accumulator, beat counter and config capture.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        cfg_len_d = cfg_len_q;
        cfg_sat_d = cfg_sat_q;
        push      = 1'b0;
        push_data = {sat_q | beat_clip, beat_sum};
        unique case (state_q)
            IDLE: begin
                if (mac_out_pvld) begin
                    acc_d = data_ext;
                    cnt_d = LEN_W'(1);
                    sat_d = 1'b0;
                    if (cfg_len_q == '0) begin
                        push      = 1'b1;
                        push_data = {1'b0, data_ext};
                    end else begin
                        state_d = ACC;
                    end
                end else if (cfg_reg_en) begin
                    cfg_len_d = cfg_acc_len;
                    cfg_sat_d = cfg_sat_en;
                end
            end
            ACC: begin
                if (mac_out_pvld) begin
                    if (cnt_q == cfg_len_q) begin
                        push    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        acc_d = beat_sum;
                        cnt_d = cnt_q + 1'b1;
                        sat_d = sat_q | beat_clip;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky drop flag: a result met a full FIFO with no pop to make room.
    always_comb begin
        err_d = err_q | (push & fifo_full & ~pop);
    end

    // State registers.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            cfg_len_q <= '0;
            cfg_sat_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            cfg_len_q <= cfg_len_d;
            cfg_sat_q <= cfg_sat_d;
            err_q     <= err_d;
        end
    end

    mac_acc_fifo #(
        .W     (ACC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (nvdla_core_clk),
        .rst_i       (nvdla_core_rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign acc_out_data = fifo_head[ACC_W-1:0];
    assign acc_out_sat  = fifo_head[ACC_W];
    assign acc_out_pvld = ~fifo_empty;
    assign acc_busy     = (state_q == ACC) | ~fifo_empty;
    assign acc_ovf_err  = err_q;

endmodule

// File: tb/tb_mac_acc_unit.sv
// tb_mac_acc_unit: scoreboard bench for mac_acc_unit (ACC_W=32 instance
// plus an ACC_W=20 instance for the saturation/wrap vectors).
module tb_mac_acc_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        cfg_en;
    logic [7:0]  cfg_len;
    logic        cfg_sat;
    logic [18:0] data;
    logic        pvld;
    logic        prdy;
    logic [31:0] o_data;
    logic        o_sat;
    logic        o_pvld;
    logic        busy;
    logic        err;

    logic        b_cfg_en;
    logic [7:0]  b_cfg_len;
    logic        b_cfg_sat;
    logic [18:0] b_data;
    logic        b_pvld;
    logic        b_prdy;
    logic [19:0] b_o_data;
    logic        b_o_sat;
    logic        b_o_pvld;
    logic        b_busy;
    logic        b_err;

    int errors = 0;
    int checks = 0;

    logic [32:0] expq[$];
    logic [20:0] expq_b[$];

    always #5 clk = ~clk;

    mac_acc_unit #(
        .IN_W(19), .ACC_W(32), .LEN_W(8), .FIFO_DEPTH(4)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_reg_en     (cfg_en),
        .cfg_acc_len    (cfg_len),
        .cfg_sat_en     (cfg_sat),
        .mac_out_data   (data),
        .mac_out_pvld   (pvld),
        .acc_out_data   (o_data),
        .acc_out_sat    (o_sat),
        .acc_out_pvld   (o_pvld),
        .acc_out_prdy   (prdy),
        .acc_busy       (busy),
        .acc_ovf_err    (err)
    );

    mac_acc_unit #(
        .IN_W(19), .ACC_W(20), .LEN_W(8), .FIFO_DEPTH(4)
    ) dut20 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_reg_en     (b_cfg_en),
        .cfg_acc_len    (b_cfg_len),
        .cfg_sat_en     (b_cfg_sat),
        .mac_out_data   (b_data),
        .mac_out_pvld   (b_pvld),
        .acc_out_data   (b_o_data),
        .acc_out_sat    (b_o_sat),
        .acc_out_pvld   (b_o_pvld),
        .acc_out_prdy   (b_prdy),
        .acc_busy       (b_busy),
        .acc_ovf_err    (b_err)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor for the 32-bit instance: every accepted output is scored.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && o_pvld && prdy) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_a_unexpected: got %0h expected none",
                         {o_sat, o_data});
            end else begin
                e = expq.pop_front();
                chk("out_a", 64'({o_sat, o_data}), 64'(e));
            end
        end
    end

    // Monitor for the 20-bit instance.
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst && b_o_pvld && b_prdy) begin
            if (expq_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_b_unexpected: got %0h expected none",
                         {b_o_sat, b_o_data});
            end else begin
                e = expq_b.pop_front();
                chk("out_b", 64'({b_o_sat, b_o_data}), 64'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic beat(input int d);
        data = d[18:0];
        pvld = 1'b1;
        step();
        pvld = 1'b0;
    endtask

    task automatic b_beat(input int d);
        b_data = d[18:0];
        b_pvld = 1'b1;
        step();
        b_pvld = 1'b0;
    endtask

    task automatic cfg(input int len, input bit s);
        cfg_en  = 1'b1;
        cfg_len = len[7:0];
        cfg_sat = s;
        step();
        cfg_en  = 1'b0;
    endtask

    task automatic b_cfg(input int len, input bit s);
        b_cfg_en  = 1'b1;
        b_cfg_len = len[7:0];
        b_cfg_sat = s;
        step();
        b_cfg_en  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results missing, expected 0",
                     name, expq.size());
        end
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while (expq_b.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (expq_b.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results missing, expected 0",
                     name, expq_b.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_en    = 1'b0;
        cfg_len   = '0;
        cfg_sat   = 1'b0;
        data      = '0;
        pvld      = 1'b0;
        prdy      = 1'b1;
        b_cfg_en  = 1'b0;
        b_cfg_len = '0;
        b_cfg_sat = 1'b0;
        b_data    = '0;
        b_pvld    = 1'b0;
        b_prdy    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_pvld", 64'(o_pvld), 64'd0);
        chk("rst_data", 64'({o_sat, o_data}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        step();
        rst = 1'b0;
        step();

        // T1: len=3, sat=1, bubbles between beats -> 58
        cfg(3, 1'b1);
        beat(100);
        step();
        beat(-50);
        step();
        beat(7);
        at_neg();
        chk("t1_no_early", 64'(o_pvld), 64'd0);
        chk("t1_busy_acc", 64'(busy), 64'd1);
        expq.push_back({1'b0, 32'd58});
        beat(1);
        at_neg();
        chk("t1_latency", 64'(o_pvld), 64'd1);
        drain("t1_drain");

        // T2: len=0 passes each beat straight through
        cfg(0, 1'b0);
        expq.push_back({1'b0, 32'hFFFC0000});
        beat(-262144);
        at_neg();
        chk("t2_latency0", 64'(o_pvld), 64'd1);
        expq.push_back({1'b0, 32'h0003FFFF});
        beat(262143);
        at_neg();
        chk("t2_latency1", 64'(o_pvld), 64'd1);
        drain("t2_drain");

        // T3: ACC_W=20 saturate then wrap
        b_cfg(2, 1'b1);
        expq_b.push_back({1'b1, 20'd524287});
        repeat (3) b_beat(262143);
        drain_b("t3_sat_drain");
        b_cfg(2, 1'b0);
        expq_b.push_back({1'b0, 20'hBFFFD});
        repeat (3) b_beat(262143);
        drain_b("t3_wrap_drain");

        // T4: stalled output, fifth result dropped
        prdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expq.push_back({1'b0, 32'(i)});
            beat(i);
        end
        at_neg();
        chk("t4_pvld", 64'(o_pvld), 64'd1);
        chk("t4_head", 64'(o_data), 64'd1);
        chk("t4_err", 64'(err), 64'd1);
        step();
        repeat (3) step();
        at_neg();
        chk("t4_head_held", 64'({o_sat, o_data}), 64'd1);
        step();
        prdy = 1'b1;
        drain("t4_drain");
        chk("t4_err_sticky", 64'(err), 64'd1);

        do_reset();
        at_neg();
        chk("rst_err_clear", 64'(err), 64'd0);
        step();

        // T5: push and pop in the same cycle while full
        prdy = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            expq.push_back({1'b0, 32'(i)});
            beat(i);
        end
        prdy = 1'b1;
        expq.push_back({1'b0, 32'd14});
        beat(14);
        prdy = 1'b0;
        at_neg();
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_pvld", 64'(o_pvld), 64'd1);
        chk("t5_head", 64'(o_data), 64'd11);
        step();
        prdy = 1'b1;
        drain("t5_drain");
        chk("t5_err_after", 64'(err), 64'd0);

        // T6: reset mid-accumulation discards the partial sum
        cfg(3, 1'b1);
        beat(5);
        beat(6);
        at_neg();
        chk("t6_busy_before", 64'(busy), 64'd1);
        step();
        do_reset();
        at_neg();
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_pvld", 64'(o_pvld), 64'd0);
        step();
        expq.push_back({1'b0, 32'd9});
        beat(9);
        at_neg();
        chk("t6_len0", 64'(o_pvld), 64'd1);
        drain("t6_len0_drain");

        // T6: config during ACC is ignored
        cfg(3, 1'b0);
        beat(1);
        cfg(0, 1'b1);
        beat(2);
        beat(3);
        at_neg();
        chk("t6_cfg_ignored", 64'(o_pvld), 64'd0);
        expq.push_back({1'b0, 32'd10});
        beat(4);
        drain("t6_acc_drain");

        // Config with an IDLE beat in the same cycle: old length applies
        cfg_en  = 1'b1;
        cfg_len = 8'd0;
        data    = 19'd1;
        pvld    = 1'b1;
        step();
        cfg_en  = 1'b0;
        pvld    = 1'b0;
        beat(2);
        beat(3);
        expq.push_back({1'b0, 32'd10});
        beat(4);
        drain("t6_samecyc_drain");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
